shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 164 ++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32->64 shift-add multiplier built on a two-block 32-bit CLA (start/busy/done).
// Optional signed operation is enabled by defining MULT_SIGNED_EN.

module cla16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        grp_g,
   output logic        grp_p
);
   logic [15:0] g, p, c;
   logic [3:0]  gg, gp, gc;

   always_comb begin
      g  = x & y;
      p  = x ^ y;
      gg = '0;
      gp = '0;
      c  = '0;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      gc[0] = cin;
      gc[1] = gg[0] | (gp[0] & cin);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
      // Per-nibble carries are fully expanded from the nibble carry-in.
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      sum   = p ^ c;
      grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
      grp_p = &gp;
   end
endmodule

module lcu_16to32 (
   input  logic [1:0] grp_g,
   input  logic [1:0] grp_p,
   input  logic       cin,
   output logic       c16,
   output logic       cout
);
   assign c16  = grp_g[0] | (grp_p[0] & cin);
   assign cout = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   mcand, acc_hi, acc_lo, add_b, sum, a_mag, b_mag;
   logic [CW-1:0]      cnt;
   logic               cout, c16;
   logic [1:0]         grp_g, grp_p;
   logic [2*WIDTH-1:0] acc_full, result, prod_q;

   assign add_b    = acc_lo[0] ? mcand : '0;
   assign acc_full = {acc_hi, acc_lo};

   cla16 u_cla_lo (.x(acc_hi[15:0]),  .y(add_b[15:0]),  .cin(1'b0), .sum(sum[15:0]),
                   .grp_g(grp_g[0]), .grp_p(grp_p[0]));
   cla16 u_cla_hi (.x(acc_hi[31:16]), .y(add_b[31:16]), .cin(c16),  .sum(sum[31:16]),
                   .grp_g(grp_g[1]), .grp_p(grp_p[1]));
   lcu_16to32 u_lcu (.grp_g(grp_g), .grp_p(grp_p), .cin(1'b0), .c16(c16), .cout(cout));

`ifdef MULT_SIGNED_EN
   logic neg, neg_ld;

   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_ld = 1'b0;
      if (signed_op) begin
         if (a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
         if (b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
         neg_ld = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   assign result = neg ? (~acc_full + (2*WIDTH)'(1)) : acc_full;

   always_ff @(posedge clk) begin
      if (rst)                          neg <= 1'b0;
      else if (state == IDLE && start)  neg <= neg_ld;
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;
   assign a_mag  = a;
   assign b_mag  = b;
   assign result = acc_full;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One partial-product step per RUN cycle; the 33-bit {cout,sum} shifts right into the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         prod_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               mcand  <= a_mag;
               acc_hi <= '0;
               acc_lo <= b_mag;
               cnt    <= '0;
            end
            RUN: begin
               acc_hi <= {cout, sum[WIDTH-1:1]};
               acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + CW'(1);
            end
            DONE:    prod_q <= result;
            default: ;
         endcase
      end
   end

   // The result is shown combinationally in DONE so it lines up with the done pulse.
   assign busy               = (state != IDLE);
   assign done               = (state == DONE);
   assign {prod_hi, prod_lo} = (state == DONE) ? result : prod_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: cycle-level latency model with an expected-product queue,
// per-cycle output compare, and directed vectors with literal expected products.

module tb_shift_add_multiplier;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] prod_hi, prod_lo;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .a(a), .b(b),
      .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y,
                                               input logic s);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
`ifdef MULT_SIGNED_EN
      if (s) return 64'(sx * sy);
`endif
      if (s && sx == sy) return {32'b0, x} * {32'b0, y};
      return {32'b0, x} * {32'b0, y};
   endfunction

   // Model: an accepted request produces its product 33 cycles later for one cycle.
   int          phase = 0;
   logic [63:0] exp_prod = '0;
   logic [63:0] exp_q[$];
   bit          model_live = 1'b0;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      model_live <= 1'b1;
      if (rst) begin
         phase    <= 0;
         exp_prod <= '0;
         exp_q.delete();
      end else if (phase == 0) begin
         if (start) begin
            phase <= 1;
            exp_q.push_back(model_prod(a, b, signed_op));
         end
      end else if (phase == 32) begin
         phase    <= 33;
         exp_prod <= exp_q.pop_front();
      end else if (phase == 33) begin
         phase <= 0;
      end else begin
         phase <= phase + 1;
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (model_live) begin
         chk("cyc_busy", 64'(busy), 64'(phase != 0));
         chk("cyc_done", 64'(done), 64'(phase == 33));
         chk("cyc_prod", {prod_hi, prod_lo}, exp_prod);
      end
   end

   task automatic wait_done(input int t0, input string name);
      int guard;
      guard = 0;
      while (done !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({name, "_latency"}, 64'(cyc - t0), 64'd33);
   endtask

   task automatic run_mul(input logic [31:0] ta, input logic [31:0] tb, input logic sop,
                          input logic [63:0] exp, input string name);
      int t0;
      t0        = cyc;
      a         = ta;
      b         = tb;
      signed_op = sop;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(t0, name);
      chk({name, "_prod"}, {prod_hi, prod_lo}, exp);
      @(posedge clk); #1;
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_prod", {prod_hi, prod_lo}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_mul(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, "small");
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "max");
      run_mul(32'h1234_5678, 32'd0, 1'b0, 64'd0, "zero_b");
      run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, "cross");
      run_mul(32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0, "zero_a");
`ifdef MULT_SIGNED_EN
      run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_neg");
      run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min");
      run_mul(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'h0000_0000_0000_002A, "s_negneg");
      run_mul(32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "s_off");
`else
      run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE, "u_sop");
      run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, "u_sop2");
`endif

      // start while busy is ignored; the retry at cycle 34 is accepted
      t0    = cyc;
      d0    = done_cnt;
      a     = 32'd2;
      b     = 32'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc - t0 < 10) begin
         @(posedge clk); #1;
      end
      a     = 32'd9;
      b     = 32'd9;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(t0, "busy_ign");
      chk("busy_ign_prod", {prod_hi, prod_lo}, 64'd6);
      @(posedge clk); #1;
      chk("busy_ign_idle", 64'(busy), 64'd0);
      chk("busy_ign_pulses", 64'(done_cnt - d0), 64'd1);
      t0 = cyc;
      run_mul(32'd9, 32'd9, 1'b0, 64'd81, "b2b");
      chk("b2b_total", 64'(cyc - t0), 64'd34);

      // reset in the middle of an operation
      t0    = cyc;
      a     = 32'd5;
      b     = 32'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc - t0 < 15) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
      d0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run_mul(32'd3, 32'd4, 1'b0, 64'd12, "after_rst");

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
